// File: rtl/hazard_pkg.sv
// Shared types for the execute-stage hazard/forwarding controller.
//   fwd_sel_e    : forwarding-mux select encoding
//   stage_info_t : register-use info carried by the M and W shadow stages
//   mc_state_e   : multi-cycle sequencer states
//   rd_hit()     : "this stage writes src" test (x0 never matches)
package hazard_pkg;

  localparam int HZ_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RS  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_ALU = 2'b10,
    FWD_MEM = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic [HZ_REG_AW-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } stage_info_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

  function automatic logic rd_hit(input stage_info_t s, input logic [HZ_REG_AW-1:0] src);
    return s.regwrite && (s.rd != '0) && (s.rd == src);
  endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding priority for one E-stage source operand (pure combinational).
//   src    : E-stage source register
//   m, w   : M and W stage register-use info
//   sel    : mux select (M beats W; M load only forwards when MEMFWD=1)
//   MEMFWD : 1 when the M memory output is a legal forwarding source
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter bit MEMFWD = 1'b0
) (
  input  logic [HZ_REG_AW-1:0] src,
  input  stage_info_t          m,
  input  stage_info_t          w,
  output fwd_sel_e             sel
);

  logic m_hit, w_hit;

  always_comb begin
    // Without memory forwarding a load in M has no usable value yet; the
    // load-use stall keeps that case from ever occurring.
    m_hit = rd_hit(m, src) && (MEMFWD || !m.memread);
    w_hit = rd_hit(w, src);
    sel   = FWD_RS;
    if (m_hit)      sel = m.memread ? FWD_MEM : FWD_ALU;
    else if (w_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Execute-stage hazard and forwarding controller for the 5-stage pipeline.
// Tracks shadow register-use info for E/M/W, drives the operand forwarding
// selects and sequences stalls/flushes for load-use, taken branches and
// multi-cycle E operations.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_d_rs1/rs2/rd          : decode-stage register fields
//   i_d_regwrite/memread/mc : decode-stage instruction class
//   i_e_br_taken            : branch in E resolved taken
//   o_con_fa/o_con_fb       : operand A/B forwarding selects
//   o_stall_f/d/e           : hold PC, F/D, D/E
//   o_flush_d/e/m           : clear F/D, D/E, E/M
//   o_busy                  : multi-cycle sequencer in BUSY
// Build option: define HAZ_MEMFWD_EN to forward the M memory output (select
// 11) and drop the load-use stall.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = $clog2(MC_LAT+1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_d_rs1,
  input  logic [REG_AW-1:0] i_d_rs2,
  input  logic [REG_AW-1:0] i_d_rd,
  input  logic              i_d_regwrite,
  input  logic              i_d_memread,
  input  logic              i_d_mc,
  input  logic              i_e_br_taken,
  output logic [1:0]        o_con_fa,
  output logic [1:0]        o_con_fb,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_stall_e,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_flush_m,
  output logic              o_busy
);

  localparam int NUM_OPS = 2;
`ifdef HAZ_MEMFWD_EN
  localparam bit MEMFWD = 1'b1;
`else
  localparam bit MEMFWD = 1'b0;
`endif

  logic [REG_AW-1:0] e_rs1, e_rs2;
  logic              e_mc, e_mc_d;
  stage_info_t       e_info, m_info, w_info;
  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rst_q, quiet, busy, br, ld_use;
  logic              stall_fd, stall_e, flush_d, flush_e, flush_m;

  logic [NUM_OPS-1:0][REG_AW-1:0] op_src;
  logic [NUM_OPS-1:0][1:0]        op_sel;

  // Outputs are held at zero during reset and for the first cycle after it.
  assign quiet = i_rst | rst_q;
  assign busy  = (state_q == ST_BUSY);
  assign br    = i_e_br_taken & ~busy;

`ifdef HAZ_MEMFWD_EN
  assign ld_use = 1'b0;
`else
  assign ld_use = ~busy & e_info.memread &
                  (rd_hit(e_info, i_d_rs1) | rd_hit(e_info, i_d_rs2));
`endif

  // Stall/flush priority: BUSY, then taken branch, then load-use.
  always_comb begin
    stall_fd = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    if (!quiet) begin
      if (busy) begin
        stall_fd = 1'b1;
        stall_e  = 1'b1;
        flush_m  = 1'b1;
      end else if (br) begin
        flush_d  = 1'b1;
        flush_e  = 1'b1;
      end else if (ld_use) begin
        stall_fd = 1'b1;
        flush_e  = 1'b1;
      end
    end
  end

  // mc bit E will hold next cycle.
  assign e_mc_d = flush_e ? 1'b0 : (stall_e ? e_mc : i_d_mc);

  // BUSY is entered on the edge that loads an mc op into E, so the op sits in
  // E for MC_LAT-1 held BUSY cycles plus the RUN cycle in which it leaves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (e_mc_d) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(MC_LAT-1);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_q   <= 1'b1;
      state_q <= ST_RUN;
      cnt_q   <= '0;
      e_rs1   <= '0;
      e_rs2   <= '0;
      e_mc    <= 1'b0;
      e_info  <= '0;
      m_info  <= '0;
      w_info  <= '0;
    end else begin
      rst_q   <= 1'b0;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_mc    <= e_mc_d;
      if (flush_e) begin
        e_rs1  <= '0;
        e_rs2  <= '0;
        e_info <= '0;
      end else if (!stall_e) begin
        e_rs1  <= i_d_rs1;
        e_rs2  <= i_d_rs2;
        e_info <= '{rd: i_d_rd, regwrite: i_d_regwrite, memread: i_d_memread};
      end
      m_info <= flush_m ? '0 : e_info;
      w_info <= m_info;
    end
  end

  assign op_src[0] = e_rs1;
  assign op_src[1] = e_rs2;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_sel_unit #(.MEMFWD(MEMFWD)) u_fwd (
      .src (op_src[g]),
      .m   (m_info),
      .w   (w_info),
      .sel (op_sel[g])
    );
  end

  assign o_con_fa  = quiet ? 2'b00 : op_sel[0];
  assign o_con_fb  = quiet ? 2'b00 : op_sel[1];
  assign o_stall_f = stall_fd;
  assign o_stall_d = stall_fd;
  assign o_stall_e = stall_e;
  assign o_flush_d = flush_d;
  assign o_flush_e = flush_e;
  assign o_flush_m = flush_m;
  assign o_busy    = busy & ~quiet;

`ifndef HAZ_MEMFWD_EN
  // The load-use stall must keep a load in M from feeding E directly.
  logic ld_m_hit;
  assign ld_m_hit = m_info.memread & (rd_hit(m_info, e_rs1) | rd_hit(m_info, e_rs2));
  a_no_ld_m_use: assert property (@(posedge i_clk) disable iff (quiet) !ld_m_hit);
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [4:0] i_d_rs1, i_d_rs2, i_d_rd;
  logic       i_d_regwrite, i_d_memread, i_d_mc, i_e_br_taken;
  logic [1:0] o_con_fa, o_con_fb;
  logic       o_stall_f, o_stall_d, o_stall_e, o_flush_d, o_flush_e, o_flush_m, o_busy;

  int chk  = 0;
  int errs = 0;

  // {fa, fb, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy}
  logic [10:0] outs;
  assign outs = {o_con_fa, o_con_fb, o_stall_f, o_stall_d, o_stall_e,
                 o_flush_d, o_flush_e, o_flush_m, o_busy};

  always #5 i_clk = ~i_clk;

  hazard_fwd_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_d_rs1(i_d_rs1), .i_d_rs2(i_d_rs2), .i_d_rd(i_d_rd),
    .i_d_regwrite(i_d_regwrite), .i_d_memread(i_d_memread), .i_d_mc(i_d_mc),
    .i_e_br_taken(i_e_br_taken),
    .o_con_fa(o_con_fa), .o_con_fb(o_con_fb),
    .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_stall_e(o_stall_e),
    .o_flush_d(o_flush_d), .o_flush_e(o_flush_e), .o_flush_m(o_flush_m),
    .o_busy(o_busy)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] rs1, rs2, rd, input logic rw, mr, mc);
    i_d_rs1 = rs1; i_d_rs2 = rs2; i_d_rd = rd;
    i_d_regwrite = rw; i_d_memread = mr; i_d_mc = mc;
  endtask

  task automatic nops(input int n);
    drv(0, 0, 0, 0, 0, 0);
    i_e_br_taken = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_e_br_taken = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    drv(3, 4, 5, 1, 1, 1);
    i_e_br_taken = 1'b1;
    #1;
    chk++; if (outs !== 11'b0) begin errs++; $display("FAIL rst_hold: outs=%b exp=%b", outs, 11'b0); end
    tick();
    i_rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk++; if (outs !== 11'b0) begin errs++; $display("FAIL rst_after: outs=%b exp=%b", outs, 11'b0); end
    i_e_br_taken = 1'b0;
    tick();
  endtask

  task automatic test_fwd_alu();
    drv(1, 2, 5, 1, 0, 0);                 // add x5
    tick();
    drv(5, 6, 8, 1, 0, 0);                 // dependent on x5 via rs1
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL alu_pre: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    tick();
    drv(0, 5, 10, 1, 0, 0);                // x5 via rs2, reaches E with x5 in W
    #1;
    chk++; if (outs !== 11'b10_00_0000000) begin errs++; $display("FAIL alu_m: outs=%b exp=%b", outs, 11'b10_00_0000000); end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk++; if (outs !== 11'b00_01_0000000) begin errs++; $display("FAIL alu_w: outs=%b exp=%b", outs, 11'b00_01_0000000); end
    nops(3);
  endtask

  task automatic test_fwd_prio();
    drv(0, 0, 7, 1, 0, 0); tick();        // x7 (will be in W)
    drv(0, 0, 7, 1, 0, 0); tick();        // x7 (will be in M)
    drv(0, 7, 0, 1, 0, 0); tick();        // consumer rs2=x7, writes x0
    drv(0, 0, 0, 1, 0, 0);                 // writes x0
    #1;
    chk++; if (outs !== 11'b00_10_0000000) begin errs++; $display("FAIL prio_m_over_w: outs=%b exp=%b", outs, 11'b00_10_0000000); end
    tick();
    drv(0, 0, 0, 0, 0, 0); tick();
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL x0_nofwd: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    nops(3);
  endtask

  task automatic test_load_use();
    drv(1, 0, 3, 1, 1, 0);                 // load x3
    tick();
    drv(3, 4, 9, 1, 0, 0);                 // consumer of x3
    #1;
`ifdef HAZ_MEMFWD_EN
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL lu_nostall: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk++; if (outs !== 11'b11_00_0000000) begin errs++; $display("FAIL lu_memfwd: outs=%b exp=%b", outs, 11'b11_00_0000000); end
    tick();
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL lu_after: outs=%b exp=%b", outs, 11'b00_00_0000000); end
`else
    chk++; if (outs !== 11'b00_00_1100100) begin errs++; $display("FAIL lu_stall: outs=%b exp=%b", outs, 11'b00_00_1100100); end
    tick();                                // consumer held in D
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL lu_bubble: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk++; if (outs !== 11'b01_00_0000000) begin errs++; $display("FAIL lu_wbfwd: outs=%b exp=%b", outs, 11'b01_00_0000000); end
`endif
    nops(3);
  endtask

  task automatic test_branch_ld();
    drv(1, 0, 3, 1, 1, 0);                 // load x3
    tick();
    drv(0, 3, 9, 1, 0, 0);                 // consumer, squashed by branch
    i_e_br_taken = 1'b1;
    #1;
    chk++; if (outs !== 11'b00_00_0001100) begin errs++; $display("FAIL br_over_lu: outs=%b exp=%b", outs, 11'b00_00_0001100); end
    tick();
    i_e_br_taken = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL br_after: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    nops(3);
  endtask

  task automatic test_mc();
    drv(0, 0, 12, 1, 0, 1);                // mc op writing x12
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL mc_pre: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    tick();
    drv(12, 0, 13, 1, 0, 0);               // consumer of x12, held in D
    for (int i = 0; i < 3; i++) begin
      i_e_br_taken = (i == 1);             // ignored while busy
      #1;
      chk++; if (outs !== 11'b00_00_1110011) begin errs++; $display("FAIL mc_busy%0d: outs=%b exp=%b", i, outs, 11'b00_00_1110011); end
      tick();
    end
    i_e_br_taken = 1'b0;
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL mc_run: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk++; if (outs !== 11'b10_00_0000000) begin errs++; $display("FAIL mc_in_m: outs=%b exp=%b", outs, 11'b10_00_0000000); end
    nops(3);
  endtask

  task automatic test_back_to_back();
    drv(0, 0, 14, 1, 0, 1); tick();        // mc #1 enters E
    drv(0, 0, 15, 1, 0, 1);                // mc #2 waits in D
    repeat (3) tick();
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL b2b_gap: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1;
    chk++; if (outs !== 11'b00_00_1110011) begin errs++; $display("FAIL b2b_busy2: outs=%b exp=%b", outs, 11'b00_00_1110011); end
    repeat (3) tick();
    #1;
    chk++; if (outs !== 11'b00_00_0000000) begin errs++; $display("FAIL b2b_done: outs=%b exp=%b", outs, 11'b00_00_0000000); end
    nops(3);
  endtask

  task automatic test_rst_busy();
    drv(0, 0, 12, 1, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0); tick();         // second BUSY cycle
    i_rst = 1'b1;
    #1;
    chk++; if (outs !== 11'b0) begin errs++; $display("FAIL rb_hold: outs=%b exp=%b", outs, 11'b0); end
    tick();
    i_rst = 1'b0;
    #1;
    chk++; if (outs !== 11'b0) begin errs++; $display("FAIL rb_after: outs=%b exp=%b", outs, 11'b0); end
    tick();
    #1;
    chk++; if (outs !== 11'b0) begin errs++; $display("FAIL rb_run: outs=%b exp=%b", outs, 11'b0); end
    nops(2);
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_fwd_prio();
    test_load_use();
    test_branch_ld();
    test_mc();
    test_back_to_back();
    test_rst_busy();
    $display("Result: errors=%0d of %0d checks", errs, chk);
    $finish;
  end

endmodule
